// File: rtl/switch_debounce_pkg.sv
// Shared constants for the lab switch conditioning front end.
// Bit order is {a,b,c,d,e} with a in the MSB.
package lab_pkg;

    localparam int SW_WIDTH      = 5;
    localparam int CNT_MAX_SIM   = 4;
    localparam int CNT_MAX_BOARD = 1000000;

    localparam int A_IDX = 4;
    localparam int B_IDX = 3;
    localparam int C_IDX = 2;
    localparam int D_IDX = 1;
    localparam int E_IDX = 0;

endpackage

// File: rtl/switch_debounce_if.sv
// Switch-side bundle: raw levels in, debounced levels plus status out.
// The slave modport is the debouncer's view; the master modport is the board/bench side.
interface switch_debounce_if
    import lab_pkg::*;
#(
    parameter int WIDTH = SW_WIDTH
);

    logic [WIDTH-1:0] sw_in;
    logic [WIDTH-1:0] sw_out;
    logic             changed;
    logic             busy;

    modport master (output sw_in, input sw_out, input changed, input busy);
    modport slave  (input sw_in, output sw_out, output changed, output busy);

endinterface

// File: rtl/switch_debounce_bit.sv
// One switch bit: synchroniser chain, stability counter and output flop.
// upd_o is high in the cycle before the new level becomes visible on level_o.
module debounce_bit #(
    parameter int CNT_MAX     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_i,
    output logic level_o,
    output logic upd_o,
    output logic pend_o
);

    localparam int            CW   = $clog2(CNT_MAX);
    localparam logic [CW-1:0] TERM = CW'(CNT_MAX - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic                   sync_s;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Any cycle where the synchronised level agrees with the output discards the candidate.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sw_i};
        cnt_d  = cnt_q;
        out_d  = out_q;
        upd_o  = 1'b0;
        if (sync_s == out_q) begin
            cnt_d = '0;
        end else if (cnt_q == TERM) begin
            out_d = sync_s;
            cnt_d = '0;
            upd_o = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            out_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
        end
    end

    assign level_o = out_q;
    assign pend_o  = (cnt_q != '0);

endmodule

// File: rtl/switch_debounce.sv
// Debounces the five lab slide switches and flags each settled change once.
// changed is registered from the per-bit update strobes so it lines up with the new sw_out.
module switch_debounce
    import lab_pkg::*;
#(
    parameter int WIDTH       = SW_WIDTH,
    parameter int CNT_MAX     = CNT_MAX_BOARD,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    switch_debounce_if.slave    bus
);

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] upd;
    logic [WIDTH-1:0] pend;
    logic             changed_q, changed_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .CNT_MAX     (CNT_MAX),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_bit (
            .clk     (clk),
            .rst_n   (rst_n),
            .sw_i    (bus.sw_in[i]),
            .level_o (level[i]),
            .upd_o   (upd[i]),
            .pend_o  (pend[i])
        );
    end

    assign changed_d = |upd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= changed_d;
        end
    end

    assign bus.sw_out  = level;
    assign bus.changed = changed_q;
    assign bus.busy    = |pend;

endmodule

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
- Upstream conditioning stage for the lab's 5-input combinational logic block.
- Takes the five raw board slide switches and synchronises each one to clk.
- Debounces each bit and drives clean, stable levels onto the a..e inputs of the logic block.
- Also emits a one-cycle change strobe, so downstream display or compare logic can react once per settled input change.

Parameters:
- WIDTH, 5, number of independent switch bits; bit order {a,b,c,d,e}, MSB = a.
- CNT_MAX, 1000000, consecutive stable cycles required before accepting a new level (10 ms at 100 MHz); legal range 2 to 2^24.
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser; legal range 2 to 3.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, synchronous, active-low reset.
- sw_in, input, WIDTH, raw asynchronous switch levels.
- sw_out, output, WIDTH, debounced levels; sw_out[4:0] drives {a,b,c,d,e}.
- changed, output, 1, one-cycle pulse when any sw_out bit updates.
- busy, output, 1, high while any bit's counter is non-zero (a candidate change is pending).

Behaviour:
- Reset: when rst_n is sampled low at a rising edge, the following are cleared on that edge:
  - all synchroniser flops, all counters, sw_out, changed and busy go to 0.
  - Any reset mid-count discards the pending candidate.
- Synchroniser: each bit passes through SYNC_STAGES flops. sync[i] is the last stage. No logic sits between the stages.
- Per-bit counter: width is $clog2(CNT_MAX) bits, unsigned.
  - If sync[i] == sw_out[i]: cnt[i] <= 0.
  - Else if cnt[i] == CNT_MAX-1: sw_out[i] <= sync[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - The counter never wraps; the terminal compare guarantees this.
- Glitch rejection: any mismatch lasting fewer than CNT_MAX consecutive cycles at sync[i] clears the counter and leaves sw_out[i] unchanged.
- Latency: a clean step on sw_in[i], first sampled at edge k, appears on sw_out[i] after edge k+SYNC_STAGES-1+CNT_MAX. This is exactly SYNC_STAGES+CNT_MAX-1 edges after the first sampling edge.
- changed:
  - Registered; high for exactly the one cycle in which the new sw_out value is first visible.
  - Multiple bits updating on the same edge produce a single one-cycle pulse.
  - Updates on back-to-back edges give changed high on each of those cycles.
- busy: combinational OR of (cnt[i] != 0) across all bits; 0 after reset.
- Independence: bits are fully independent. Bouncing on one bit never delays or resets another bit's counter.
- Reset released with a switch already high: that bit is treated as a change from 0. sw_out[i] rises after the normal latency, and changed pulses.
- No combinational path from sw_in to any output.

Decomposition:
- Package lab_pkg:
  - SW_WIDTH = 5.
  - CNT_MAX_SIM = 4 and CNT_MAX_BOARD = 1000000.
  - Bit-index constants A_IDX=4, B_IDX=3, C_IDX=2, D_IDX=1, E_IDX=0.
- Sub-module debounce_bit:
  - Contains one synchroniser chain, one counter and one output flop.
  - Outputs its level plus an update strobe.
  - Instantiated WIDTH times with a generate loop.
- The top level ORs the update strobes into changed (registered) and the pending flags into busy.

Test Plan (CNT_MAX=4, SYNC_STAGES=2, 10 ns clk):
1. Reset: hold rst_n=0 with sw_in=5'b11111 for 3 cycles -> sw_out=0, changed=0, busy=0 throughout; the first edge with rst_n=0 already clears state (synchronous reset verified).
2. Clean step: sw_in 00000->00001 first sampled at edge k -> sw_out=00001 after edge k+5; changed=1 for exactly that one cycle; busy high during edges k+2..k+4.
3. Glitch: pulse sw_in[4] high for 3 cycles, then low -> sw_out stays 00000, changed never asserts, busy returns to 0.
4. Simultaneous: sw_in 00000->10110 on one edge -> all three bits update on the same edge; exactly one changed pulse.
5. Reset mid-count: step sw_in[2] high, then assert rst_n=0 at edge k+3 for 1 cycle with sw_in held -> sw_out stays 0; after release, sw_out[2] rises exactly 5 edges after the first post-reset sampling edge.
6. Exhaustive: drive all 32 values of sw_in, each held 20 cycles -> sw_out equals each value after the fixed latency; 32 changed pulses counted (the first value, 00000, gives none, so the expected count is 31 plus 1 for the final return to 00000).
